multicycle_control_unit: RTL and testbench

//  Multi-cycle FSM successor to the single-cycle opcode decoder for the RV32I core.

---
 rtl/multicycle_control_unit_pkg.sv | 41 ++++
 rtl/multicycle_control_unit_ctrl_decode.sv | 50 +++++
 rtl/multicycle_control_unit.sv | 171 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants for the multi-cycle RV32I control unit: opcodes, FSM state codes,
// ALU operation selects, writeback source selects and instruction classes.
package multicycle_control_unit_pkg;

    localparam logic [6:0] OPCODE_R      = 7'h33;
    localparam logic [6:0] OPCODE_I      = 7'h13;
    localparam logic [6:0] OPCODE_LOAD   = 7'h03;
    localparam logic [6:0] OPCODE_STORE  = 7'h23;
    localparam logic [6:0] OPCODE_BRANCH = 7'h63;
    localparam logic [6:0] OPCODE_JAL    = 7'h6F;
    localparam logic [6:0] OPCODE_JALR   = 7'h67;
    localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
    localparam logic [6:0] OPCODE_LUI    = 7'h37;
    localparam logic [6:0] OPCODE_SYSTEM = 7'h73;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
    localparam logic [2:0] ST_FAULT  = 3'd6;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [1:0] RDSEL_ALU   = 2'b00;
    localparam logic [1:0] RDSEL_AUIPC = 2'b01;
    localparam logic [1:0] RDSEL_PC4   = 2'b10;
    localparam logic [1:0] RDSEL_LUI   = 2'b11;

    localparam logic [2:0] CLS_ALU     = 3'd0;
    localparam logic [2:0] CLS_LOAD    = 3'd1;
    localparam logic [2:0] CLS_STORE   = 3'd2;
    localparam logic [2:0] CLS_BRANCH  = 3'd3;
    localparam logic [2:0] CLS_SYSTEM  = 3'd4;
    localparam logic [2:0] CLS_ILLEGAL = 3'd5;

endpackage

// File: rtl/multicycle_control_unit_ctrl_decode.sv
// Combinational opcode decoder: datapath selects plus the instruction class that
// steers the control FSM.
module multicycle_control_unit_ctrl_decode
    import multicycle_control_unit_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic [1:0] rd_sel,
    output logic       pc_gen_sel,
    output logic [2:0] inst_class
);

    always_comb begin
        alu_op     = ALUOP_ADD;
        alu_src    = 1'b0;
        rd_sel     = RDSEL_ALU;
        pc_gen_sel = 1'b0;
        inst_class = CLS_ALU;
        case (opcode)
            OPCODE_R: alu_op = ALUOP_RTYPE;
            OPCODE_I: begin
                alu_op  = ALUOP_ITYPE;
                alu_src = 1'b1;
            end
            OPCODE_LOAD: begin
                alu_src    = 1'b1;
                inst_class = CLS_LOAD;
            end
            OPCODE_STORE: begin
                alu_src    = 1'b1;
                inst_class = CLS_STORE;
            end
            OPCODE_BRANCH: begin
                alu_op     = ALUOP_BRANCH;
                inst_class = CLS_BRANCH;
            end
            OPCODE_JAL:  rd_sel = RDSEL_PC4;
            OPCODE_JALR: begin
                rd_sel     = RDSEL_PC4;
                pc_gen_sel = 1'b1;
            end
            OPCODE_AUIPC:  rd_sel = RDSEL_AUIPC;
            OPCODE_LUI:    rd_sel = RDSEL_LUI;
            OPCODE_SYSTEM: inst_class = CLS_SYSTEM;
            default:       inst_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB over a
// shared memory port, enforces a memory wait timeout and counts retired instructions.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter bit          TRAP_ILLEGAL = 1'b1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic             memRead,
    output logic             memWrite,
    output logic             memtoReg,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             sys,
    output logic [1:0]       ALUOp,
    output logic [1:0]       rd_sel,
    output logic             pc_gen_sel,
    output logic             halt,
    output logic             fault,
    output logic             retire,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned     WaitW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] instret_q;
    logic             started_q;

    logic [1:0] dec_alu_op;
    logic       dec_alu_src;
    logic [1:0] dec_rd_sel;
    logic       dec_pc_gen_sel;
    logic [2:0] dec_class;

    multicycle_control_unit_ctrl_decode u_decode (
        .opcode     (opcode),
        .alu_op     (dec_alu_op),
        .alu_src    (dec_alu_src),
        .rd_sel     (dec_rd_sel),
        .pc_gen_sel (dec_pc_gen_sel),
        .inst_class (dec_class)
    );

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        mem_req    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        memtoReg   = 1'b0;
        ALUSrc     = 1'b0;
        RegWrite   = 1'b0;
        sys        = 1'b0;
        ALUOp      = ALUOP_ADD;
        rd_sel     = RDSEL_ALU;
        pc_gen_sel = 1'b0;
        halt       = 1'b0;
        fault      = 1'b0;
        retire     = 1'b0;
        // The first cycle after reset release stays idle so mem_req rises one cycle later.
        if (started_q) begin
            if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
                ALUOp      = dec_alu_op;
                ALUSrc     = dec_alu_src;
                rd_sel     = dec_rd_sel;
                pc_gen_sel = dec_pc_gen_sel;
            end
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec_class == CLS_SYSTEM) begin
                        retire  = 1'b1;
                        state_d = ST_HALT;
                    end else if (dec_class == CLS_ILLEGAL) begin
                        if (TRAP_ILLEGAL) begin
                            state_d = ST_FAULT;
                        end else begin
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (dec_class == CLS_BRANCH) begin
                        branch  = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else if (dec_class == CLS_LOAD || dec_class == CLS_STORE) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    memRead  = (dec_class == CLS_LOAD);
                    memWrite = (dec_class == CLS_STORE);
                    if (mem_ready) begin
                        retire  = memWrite;
                        state_d = memWrite ? ST_FETCH : ST_WB;
                    end
                end
                ST_WB: begin
                    RegWrite = 1'b1;
                    memtoReg = (dec_class == CLS_LOAD);
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end
                ST_HALT: begin
                    sys  = 1'b1;
                    halt = 1'b1;
                end
                ST_FAULT: fault = 1'b1;
                default:  state_d = ST_FAULT;
            endcase
            // A ready in the final wait cycle completes normally instead of faulting.
            if (mem_req) begin
                if (mem_ready) begin
                    wait_d = '0;
                end else if (wait_q == WaitLast) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            started_q <= 1'b1;
            if (retire) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench: per-instruction expected output traces are built from the opcode table
// and chosen memory latencies, and compared cycle by cycle on two differently configured DUTs.
module tb_multicycle_control_unit;

    localparam int TA = 4;
    localparam int TB = 16;

    localparam int BREQ = 17, BIR = 16, BPC = 15, BBR = 14, BMR = 13, BMW = 12, BM2R = 11;
    localparam int BSRC = 10, BRW = 9, BSYS = 8, BHALT = 2, BFLT = 1, BRET = 0;

    localparam int KALU = 0, KLD = 1, KST = 2, KBR = 3, KSYS = 4, KILL = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v [2];
    logic [6:0] op_v  [2];
    logic       rdy_v [2];

    logic        a_req, a_ir, a_pc, a_br, a_mr, a_mw, a_m2r, a_src, a_rw, a_sys;
    logic [1:0]  a_aluop, a_rdsel;
    logic        a_pcg, a_halt, a_flt, a_ret;
    logic [3:0]  a_instret;
    logic        b_req, b_ir, b_pc, b_br, b_mr, b_mw, b_m2r, b_src, b_rw, b_sys;
    logic [1:0]  b_aluop, b_rdsel;
    logic        b_pcg, b_halt, b_flt, b_ret;
    logic [31:0] b_instret;

    wire [17:0] obs_a = {a_req, a_ir, a_pc, a_br, a_mr, a_mw, a_m2r, a_src, a_rw, a_sys,
                         a_aluop, a_rdsel, a_pcg, a_halt, a_flt, a_ret};
    wire [17:0] obs_b = {b_req, b_ir, b_pc, b_br, b_mr, b_mw, b_m2r, b_src, b_rw, b_sys,
                         b_aluop, b_rdsel, b_pcg, b_halt, b_flt, b_ret};

    multicycle_control_unit #(.MEM_TIMEOUT(TA), .TRAP_ILLEGAL(1'b1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst_v[0]), .opcode(op_v[0]), .mem_ready(rdy_v[0]),
        .mem_req(a_req), .ir_write(a_ir), .pc_write(a_pc), .branch(a_br),
        .memRead(a_mr), .memWrite(a_mw), .memtoReg(a_m2r), .ALUSrc(a_src),
        .RegWrite(a_rw), .sys(a_sys), .ALUOp(a_aluop), .rd_sel(a_rdsel),
        .pc_gen_sel(a_pcg), .halt(a_halt), .fault(a_flt), .retire(a_ret),
        .instret(a_instret)
    );

    multicycle_control_unit #(.MEM_TIMEOUT(TB), .TRAP_ILLEGAL(1'b0), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst_v[1]), .opcode(op_v[1]), .mem_ready(rdy_v[1]),
        .mem_req(b_req), .ir_write(b_ir), .pc_write(b_pc), .branch(b_br),
        .memRead(b_mr), .memWrite(b_mw), .memtoReg(b_m2r), .ALUSrc(b_src),
        .RegWrite(b_rw), .sys(b_sys), .ALUOp(b_aluop), .rd_sel(b_rdsel),
        .pc_gen_sel(b_pcg), .halt(b_halt), .fault(b_flt), .retire(b_ret),
        .instret(b_instret)
    );

    int total = 0;
    int bad   = 0;
    int unsigned exp_instret [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] bv(input int b);
        logic [17:0] one = 18'd1;
        return one << b;
    endfunction

    function automatic logic [17:0] get_obs(input int s);
        return (s == 0) ? obs_a : obs_b;
    endfunction

    function automatic logic [31:0] get_instret(input int s);
        return (s == 0) ? 32'(a_instret) : b_instret;
    endfunction

    function automatic int tmo(input int s);
        return (s == 0) ? TA : TB;
    endfunction

    function automatic logic [17:0] alu_bits(input logic [1:0] aluop, input logic src,
                                             input logic [1:0] rdsel, input logic pcg);
        logic [17:0] v = '0;
        v[7:6]  = aluop;
        v[5:4]  = rdsel;
        v[3]    = pcg;
        v[BSRC] = src;
        return v;
    endfunction

    // Reference opcode table: class and the ALUOp/ALUSrc/rd_sel/pc_gen_sel fields.
    task automatic ref_info(input logic [6:0] op, output int kind, output logic [17:0] alu);
        kind = KALU;
        alu  = '0;
        case (op)
            7'h33: alu = alu_bits(2'b10, 1'b0, 2'b00, 1'b0);
            7'h13: alu = alu_bits(2'b11, 1'b1, 2'b00, 1'b0);
            7'h03: begin kind = KLD; alu = alu_bits(2'b00, 1'b1, 2'b00, 1'b0); end
            7'h23: begin kind = KST; alu = alu_bits(2'b00, 1'b1, 2'b00, 1'b0); end
            7'h63: begin kind = KBR; alu = alu_bits(2'b01, 1'b0, 2'b00, 1'b0); end
            7'h6F: alu = alu_bits(2'b00, 1'b0, 2'b10, 1'b0);
            7'h67: alu = alu_bits(2'b00, 1'b0, 2'b10, 1'b1);
            7'h17: alu = alu_bits(2'b00, 1'b0, 2'b01, 1'b0);
            7'h37: alu = alu_bits(2'b00, 1'b0, 2'b11, 1'b0);
            7'h73: kind = KSYS;
            default: kind = KILL;
        endcase
    endtask

    // One clock cycle: drive mem_ready, compare all strobes mid-cycle, advance.
    task automatic cyc(input int s, input logic rdy, input logic [17:0] exp, input string tag);
        rdy_v[s] = rdy;
        @(negedge clk);
        check(tag, 32'(get_obs(s)), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic retired(input int s);
        exp_instret[s] = exp_instret[s] + 1;
        if (s == 0) exp_instret[s] = exp_instret[s] & 32'hF;
        check("instret", get_instret(s), exp_instret[s]);
    endtask

    task automatic do_reset(input int s);
        rst_v[s] = 1'b0;
        rdy_v[s] = 1'($urandom);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_outputs", 32'(get_obs(s)), 32'd0);
        check("rst_instret", get_instret(s), 32'd0);
        @(posedge clk);
        #1;
        rst_v[s] = 1'b1;
        @(negedge clk);
        check("rst_release_idle", 32'(get_obs(s)), 32'd0);
        @(posedge clk);
        #1;
        exp_instret[s] = 0;
    endtask

    // Executes one instruction with df fetch wait cycles and dm memory wait cycles.
    task automatic run_instr(input int s, input logic [6:0] op, input int df, input int dm,
                             input bit abort);
        int          kind;
        logic [17:0] alu;
        logic [17:0] mb;
        ref_info(op, kind, alu);
        for (int i = 0; i < df && i < tmo(s); i++) begin
            op_v[s] = 7'($urandom);
            cyc(s, 1'b0, bv(BREQ), "fetch_wait");
        end
        if (df >= tmo(s)) begin
            cyc(s, 1'($urandom), bv(BFLT), "fetch_timeout");
            check("fault_instret", get_instret(s), exp_instret[s]);
            do_reset(s);
            return;
        end
        op_v[s] = op;
        cyc(s, 1'b1, bv(BREQ) | bv(BIR) | bv(BPC), "fetch_done");
        if (kind == KSYS) begin
            cyc(s, 1'($urandom), bv(BRET), "decode_sys");
            retired(s);
            for (int i = 0; i < 20; i++) cyc(s, 1'($urandom), bv(BSYS) | bv(BHALT), "halted");
            check("halt_instret", get_instret(s), exp_instret[s]);
            do_reset(s);
            return;
        end
        if (kind == KILL) begin
            if (s == 0) begin
                cyc(s, 1'($urandom), '0, "decode_illegal");
                cyc(s, 1'($urandom), bv(BFLT), "illegal_fault");
                check("fault_instret", get_instret(s), exp_instret[s]);
                do_reset(s);
            end else begin
                cyc(s, 1'($urandom), bv(BRET), "decode_nop");
                retired(s);
            end
            return;
        end
        cyc(s, 1'($urandom), '0, "decode");
        if (kind == KBR) begin
            cyc(s, 1'($urandom), alu | bv(BBR) | bv(BRET), "exec_branch");
            retired(s);
            return;
        end
        cyc(s, 1'($urandom), alu, "exec");
        if (kind == KLD || kind == KST) begin
            mb = alu | bv(BREQ) | ((kind == KLD) ? bv(BMR) : bv(BMW));
            if (abort) begin
                cyc(s, 1'b0, mb, "mem_before_abort");
                do_reset(s);
                return;
            end
            for (int i = 0; i < dm && i < tmo(s); i++) cyc(s, 1'b0, mb, "mem_wait");
            if (dm >= tmo(s)) begin
                cyc(s, 1'($urandom), bv(BFLT), "mem_timeout");
                check("fault_instret", get_instret(s), exp_instret[s]);
                do_reset(s);
                return;
            end
            cyc(s, 1'b1, mb | ((kind == KST) ? bv(BRET) : '0), "mem_done");
            if (kind == KST) begin
                retired(s);
                return;
            end
        end
        cyc(s, 1'($urandom), alu | bv(BRW) | bv(BRET) | ((kind == KLD) ? bv(BM2R) : '0), "wb");
        retired(s);
    endtask

    function automatic logic [6:0] rand_op();
        logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h17,
                                 7'h37, 7'h73, 7'h7F, 7'h00};
        return ops[$urandom_range(0, 11)];
    endfunction

    function automatic int rand_delay(input int s);
        if ($urandom_range(0, 9) == 0) return tmo(s) + int'($urandom_range(0, 1));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_v[s]       = 1'b0;
            op_v[s]        = 7'h00;
            rdy_v[s]       = 1'b0;
            exp_instret[s] = 0;
        end
        @(posedge clk);
        #1;
        do_reset(0);
        run_instr(0, 7'h33, 0, 0, 1'b0);
        run_instr(0, 7'h03, 3, 2, 1'b0);
        run_instr(0, 7'h23, 0, TA, 1'b0);
        run_instr(0, 7'h23, 0, TA - 1, 1'b0);
        run_instr(0, 7'h13, TA - 1, 0, 1'b0);
        run_instr(0, 7'h73, 1, 0, 1'b0);
        run_instr(0, 7'h7F, 0, 0, 1'b0);
        run_instr(0, 7'h33, 0, 0, 1'b0);
        run_instr(0, 7'h03, 0, 2, 1'b1);
        run_instr(0, 7'h63, 0, 0, 1'b0);
        for (int i = 0; i < 18; i++) run_instr(0, 7'h13, 0, 0, 1'b0);
        for (int i = 0; i < 150; i++) begin
            run_instr(0, rand_op(), rand_delay(0), rand_delay(0), ($urandom_range(0, 19) == 0));
        end
        do_reset(1);
        run_instr(1, 7'h7F, 0, 0, 1'b0);
        run_instr(1, 7'h23, 0, TB - 1, 1'b0);
        for (int i = 0; i < 60; i++) begin
            run_instr(1, rand_op(), rand_delay(1), rand_delay(1), 1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
